// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one RV32 R-type op, decodes it to an
// ALU sel, holds the registered operands for a fixed settle budget, then returns the result.
module alu_issue_ctrl #(
    parameter int SIMPLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_illegal
);
    localparam int MAXC = (MULDIV_CYCLES > SIMPLE_CYCLES) ? MULDIV_CYCLES : SIMPLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [6:0] OP_R = 7'b0110011;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          divzero;

    logic       dec_legal;
    logic       dec_swap;
    logic       dec_muldiv;
    logic [3:0] dec_sel;
    logic       unused_fields;

    assign unused_fields = ^{instr[24:15], instr[11:7]};
    assign in_ready = (state == IDLE);

    // Key is {funct7, funct3}
    always_comb begin
        dec_legal  = 1'b1;
        dec_swap   = 1'b0;
        dec_muldiv = 1'b0;
        dec_sel    = 4'b0000;
        if (instr[6:0] != OP_R) begin
            dec_legal = 1'b0;
        end else begin
            case ({instr[31:25], instr[14:12]})
                10'b0000000_000: dec_sel = 4'b0000;
                10'b0100000_000: dec_sel = 4'b0001;
                10'b0000000_100: dec_sel = 4'b1010;
                10'b0000000_110: dec_sel = 4'b1001;
                10'b0000000_111: dec_sel = 4'b1000;
                10'b0000000_011: begin
                    // rs1 < rs2 computed as A > B with operands swapped
                    dec_sel  = 4'b1110;
                    dec_swap = 1'b1;
                end
                10'b0000001_000: begin
                    dec_sel    = 4'b0010;
                    dec_muldiv = 1'b1;
                end
                10'b0000001_101: begin
                    dec_sel    = 4'b0011;
                    dec_muldiv = 1'b1;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            divzero     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= 4'b0000;
            res_data    <= '0;
            res_valid   <= 1'b0;
            res_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (dec_legal) begin
                            alu_a   <= dec_swap ? rs2_val : rs1_val;
                            alu_b   <= dec_swap ? rs1_val : rs2_val;
                            alu_sel <= dec_sel;
                            divzero <= (dec_sel == 4'b0011) && (rs2_val == 32'd0);
                            cnt     <= dec_muldiv ? CW'(MULDIV_CYCLES - 1) : CW'(SIMPLE_CYCLES - 1);
                            state   <= EXEC;
                        end else begin
                            divzero     <= 1'b0;
                            res_data    <= '0;
                            res_illegal <= 1'b1;
                            res_valid   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        res_data    <= divzero ? 32'hFFFF_FFFF : alu_out;
                        res_illegal <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
